// File: rtl/fft_peak_detect_if.sv
// Stream-in / peak-result bundle for fft_peak_detect.
// FFT_PEAK_THRESH_EN adds the thresh input and hit_cnt output.
interface fft_peak_detect_if #(
    parameter int DATA_W = 16,
    parameter int BIN_W  = 8
);
    logic                       valid_in;
    logic                       sop_in;
    logic signed [DATA_W-1:0]   re_in;
    logic signed [DATA_W-1:0]   im_in;
    logic [BIN_W-1:0]           peak_bin;
    logic [2*DATA_W-1:0]        peak_pow;
    logic                       frame_done;
    logic                       frame_err;
    logic                       busy;
`ifdef FFT_PEAK_THRESH_EN
    logic [2*DATA_W-1:0]        thresh;
    logic [BIN_W:0]             hit_cnt;

    modport master (
        output valid_in, sop_in, re_in, im_in, thresh,
        input  peak_bin, peak_pow, frame_done, frame_err, busy, hit_cnt
    );
    modport slave (
        input  valid_in, sop_in, re_in, im_in, thresh,
        output peak_bin, peak_pow, frame_done, frame_err, busy, hit_cnt
    );
`else
    modport master (
        output valid_in, sop_in, re_in, im_in,
        input  peak_bin, peak_pow, frame_done, frame_err, busy
    );
    modport slave (
        input  valid_in, sop_in, re_in, im_in,
        output peak_bin, peak_pow, frame_done, frame_err, busy
    );
`endif
endinterface

// File: rtl/fft_peak_detect.sv
// Per-frame peak-power bin finder behind fft_256: square, sum, compare pipeline.
// Optional FFT_PEAK_THRESH_EN counts bins whose power exceeds bus.thresh.
module fft_peak_detect #(
    parameter int DATA_W   = 16,
    parameter int N_POINTS = 256,
    parameter int BIN_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    fft_peak_detect_if.slave bus
);
    localparam int POW_W  = 2*DATA_W;
    localparam int STAGES = 2;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_POINTS-1);

    typedef enum logic {IDLE, ACCUM} state_t;

    typedef struct packed {
        logic             sop;
        logic             last;
        logic [BIN_W-1:0] bin;
    } tag_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   cnt_q, cnt_d;
    logic               s0_vld, s0_err;
    tag_t               s0_tag;

    // Frame FSM: tags each accepted sample, drops strays seen while IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s0_vld  = 1'b0;
        s0_err  = 1'b0;
        s0_tag  = '{sop: 1'b0, last: 1'b0, bin: cnt_q};
        if (bus.valid_in) begin
            if (bus.sop_in) begin
                s0_vld     = 1'b1;
                s0_err     = (state_q == ACCUM) && (cnt_q != '0);
                s0_tag.sop = 1'b1;
                s0_tag.bin = '0;
                state_d    = ACCUM;
                cnt_d      = BIN_W'(1);
            end else if (state_q == ACCUM) begin
                s0_vld = 1'b1;
                if (cnt_q == LAST_BIN) begin
                    s0_tag.last = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sign-extend before squaring so the product is formed at full width.
    logic signed [POW_W-1:0] re_x, im_x;
    assign re_x = POW_W'(bus.re_in);
    assign im_x = POW_W'(bus.im_in);

    logic [STAGES:1]   vld_pipe;
    tag_t              tag1, tag2;
    logic [POW_W-1:0]  sq_re1, sq_im1, pow2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag1     <= '0;
            tag2     <= '0;
            sq_re1   <= '0;
            sq_im1   <= '0;
            pow2     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], s0_vld};
            if (s0_vld) begin
                tag1   <= s0_tag;
                sq_re1 <= re_x * re_x;
                sq_im1 <= im_x * im_x;
            end
            if (vld_pipe[1]) begin
                tag2 <= tag1;
                pow2 <= sq_re1 + sq_im1;
            end
        end
    end

    // Strict compare keeps the lowest bin on ties; sop reloads unconditionally.
    logic [BIN_W-1:0] trk_bin, nxt_bin;
    logic [POW_W-1:0] trk_pow, nxt_pow;
    logic             upd;

    always_comb begin
        upd     = tag2.sop || (pow2 > trk_pow);
        nxt_bin = upd ? tag2.bin : trk_bin;
        nxt_pow = upd ? pow2     : trk_pow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_bin        <= '0;
            trk_pow        <= '0;
            bus.peak_bin   <= '0;
            bus.peak_pow   <= '0;
            bus.frame_done <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.frame_done <= vld_pipe[STAGES] && tag2.last;
            bus.frame_err  <= s0_err;
            if (vld_pipe[STAGES]) begin
                trk_bin <= nxt_bin;
                trk_pow <= nxt_pow;
                if (tag2.last) begin
                    bus.peak_bin <= nxt_bin;
                    bus.peak_pow <= nxt_pow;
                end
            end
        end
    end

`ifdef FFT_PEAK_THRESH_EN
    logic [BIN_W:0] trk_hits, nxt_hits;

    always_comb begin
        nxt_hits = (tag2.sop ? '0 : trk_hits) + {{BIN_W{1'b0}}, (pow2 > bus.thresh)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_hits    <= '0;
            bus.hit_cnt <= '0;
        end else if (vld_pipe[STAGES]) begin
            trk_hits <= nxt_hits;
            if (tag2.last)
                bus.hit_cnt <= nxt_hits;
        end
    end
`endif

    assign bus.busy = (state_q == ACCUM) || (|vld_pipe);

endmodule
